multi_zone_lamp_ctrl: RTL and testbench



---
 rtl/home_auto_pkg.sv | 27 ++
 rtl/lamp_zone_ctrl.sv | 79 +++++++
 rtl/multi_zone_lamp_ctrl.sv | 35 +++
 tb/tb_multi_zone_lamp_ctrl.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/home_auto_pkg.sv
// Shared types and helpers for the home-automation lamp controllers.
package home_auto_pkg;

  typedef enum logic [1:0] {
    ZS_OFF  = 2'd0,
    ZS_ON   = 2'd1,
    ZS_HOLD = 2'd2
  } zone_state_t;

  localparam int unsigned BLUE   = 0;
  localparam int unsigned RED    = 1;
  localparam int unsigned GREEN  = 2;
  localparam int unsigned YELLOW = 3;
  localparam int unsigned WHITE  = 4;

  // Widest one-hot lamp the helper can produce; callers slice down to their width.
  localparam int unsigned MAX_COLORS = 32;

  function automatic logic [MAX_COLORS-1:0] color_onehot(input int unsigned code,
                                                         input int unsigned num_colors);
    color_onehot = '0;
    if (code < num_colors && code < MAX_COLORS) begin
      color_onehot = MAX_COLORS'(1) << code;
    end
  endfunction

endpackage

// File: rtl/lamp_zone_ctrl.sv
// One lamp zone: OFF/ON/HOLD occupancy FSM with hold timer and registered lamp/active.
module lamp_zone_ctrl
  import home_auto_pkg::*;
#(
  parameter int unsigned NUM_COLORS  = 5,
  parameter int unsigned SEL_W       = 3,
  parameter int unsigned HOLD_CYCLES = 1000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  dark,
  input  logic                  motion,
  input  logic [SEL_W-1:0]      color_select,
  output logic [NUM_COLORS-1:0] lamp,
  output logic                  active
);

  localparam int unsigned TIMER_W = $clog2(HOLD_CYCLES + 1);
  localparam logic [TIMER_W-1:0] HOLD_LOAD = TIMER_W'(HOLD_CYCLES - 1);

  zone_state_t             state_q, state_d;
  logic [TIMER_W-1:0]      timer_q, timer_d;
  logic [NUM_COLORS-1:0]   lamp_d;
  logic                    active_d;
  logic [MAX_COLORS-1:0]   onehot_full;

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    unique case (state_q)
      ZS_OFF: begin
        if (dark && motion) state_d = ZS_ON;
      end
      ZS_ON: begin
        if (!dark) begin
          state_d = ZS_OFF;
        end else if (!motion) begin
          state_d = ZS_HOLD;
          timer_d = HOLD_LOAD;
        end
      end
      ZS_HOLD: begin
        // Darkness loss beats retrigger; retrigger beats expiry.
        if (!dark) begin
          state_d = ZS_OFF;
        end else if (motion) begin
          state_d = ZS_ON;
        end else if (timer_q == '0) begin
          state_d = ZS_OFF;
        end else begin
          timer_d = timer_q - TIMER_W'(1);
        end
      end
      default: state_d = ZS_OFF;
    endcase
  end

  // Colour is taken live each cycle rather than latched at turn-on.
  always_comb begin
    onehot_full = color_onehot(32'(color_select), NUM_COLORS);
    active_d    = (state_d != ZS_OFF);
    lamp_d      = active_d ? onehot_full[NUM_COLORS-1:0] : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ZS_OFF;
      timer_q <= '0;
      lamp    <= '0;
      active  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      lamp    <= lamp_d;
      active  <= active_d;
    end
  end

endmodule

// File: rtl/multi_zone_lamp_ctrl.sv
// Multi-zone lamp controller: one independent lamp_zone_ctrl per zone, sharing only dark.
module multi_zone_lamp_ctrl
  import home_auto_pkg::*;
#(
  parameter int unsigned NUM_ZONES   = 4,
  parameter int unsigned NUM_COLORS  = 5,
  parameter int unsigned SEL_W       = 3,
  parameter int unsigned HOLD_CYCLES = 1000
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            dark,
  input  logic [NUM_ZONES-1:0]            motion,
  input  logic [NUM_ZONES*SEL_W-1:0]      color_select,
  output logic [NUM_ZONES*NUM_COLORS-1:0] lamp,
  output logic [NUM_ZONES-1:0]            active
);

  for (genvar z = 0; z < NUM_ZONES; z++) begin : g_zone
    lamp_zone_ctrl #(
      .NUM_COLORS  (NUM_COLORS),
      .SEL_W       (SEL_W),
      .HOLD_CYCLES (HOLD_CYCLES)
    ) u_zone (
      .clk          (clk),
      .rst          (rst),
      .dark         (dark),
      .motion       (motion[z]),
      .color_select (color_select[z*SEL_W +: SEL_W]),
      .lamp         (lamp[z*NUM_COLORS +: NUM_COLORS]),
      .active       (active[z])
    );
  end

endmodule

// File: tb/tb_multi_zone_lamp_ctrl.sv
// Directed plus randomized bench for multi_zone_lamp_ctrl against a lit-time countdown model.
module tb_multi_zone_lamp_ctrl;
  import home_auto_pkg::*;

  localparam int unsigned NZ = 4;
  localparam int unsigned NC = 5;
  localparam int unsigned SW = 3;
  localparam int unsigned HC = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             dark = 1'b0;
  logic [NZ-1:0]    motion = '0;
  logic [NZ*SW-1:0] color_select = '0;
  logic [NZ*NC-1:0] lamp;
  logic [NZ-1:0]    active;

  int checks = 0;
  int errors = 0;

  // Model: whether each zone is lit, and how many more quiet edges it may stay lit.
  bit lit [NZ];
  int left[NZ];

  always #5 clk = ~clk;

  multi_zone_lamp_ctrl #(
    .NUM_ZONES   (NZ),
    .NUM_COLORS  (NC),
    .SEL_W       (SW),
    .HOLD_CYCLES (HC)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .dark         (dark),
    .motion       (motion),
    .color_select (color_select),
    .lamp         (lamp),
    .active       (active)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [NZ*SW-1:0] sels(input int s0, input int s1, input int s2,
                                            input int s3);
    logic [NZ*SW-1:0] v;
    v = {SW'(s3), SW'(s2), SW'(s1), SW'(s0)};
    return v;
  endfunction

  task automatic model_edge(input logic r, input logic d, input logic [NZ-1:0] m);
    for (int z = 0; z < NZ; z++) begin
      if (r || !d) begin
        lit[z] = 0; left[z] = 0;
      end else if (m[z]) begin
        lit[z] = 1; left[z] = HC;
      end else if (lit[z]) begin
        if (left[z] == 0) lit[z] = 0;
        else left[z] = left[z] - 1;
      end
    end
  endtask

  // Apply one cycle of inputs, advance the model, then compare full buses after the edge.
  task automatic step(input logic r, input logic d, input logic [NZ-1:0] m,
                      input logic [NZ*SW-1:0] cs, input string tag);
    logic [NZ*NC-1:0] exp_lamp;
    logic [NZ-1:0]    exp_act;
    int               code;
    rst = r; dark = d; motion = m; color_select = cs;
    @(posedge clk);
    model_edge(r, d, m);
    exp_lamp = '0;
    exp_act  = '0;
    for (int z = 0; z < NZ; z++) begin
      code = int'(cs[z*SW +: SW]);
      exp_act[z] = lit[z];
      if (lit[z] && code < NC) exp_lamp[z*NC + code] = 1'b1;
    end
    #1;
    check({tag, ".lamp"}, 32'(lamp), 32'(exp_lamp));
    check({tag, ".active"}, 32'(active), 32'(exp_act));
  endtask

  initial begin
    logic [NZ*SW-1:0] cs;
    logic [NZ-1:0]    m;
    logic             d, r;

    // 1: reset with everything asserted, then first light-up on RED.
    cs = sels(RED, 0, 0, 0);
    step(1, 1, 4'hf, cs, "rst0");
    check("rst0.zero", 32'(lamp), 32'd0);
    step(1, 1, 4'hf, cs, "rst1");
    step(0, 1, 4'b0001, cs, "release");
    check("release.z0", 32'(lamp[4:0]), 32'b00010);

    // 2: GREEN, then undisturbed hold of exactly HC cycles.
    cs = sels(GREEN, 0, 0, 0);
    step(0, 1, 4'b0001, cs, "green");
    for (int i = 0; i <= HC; i++) begin
      step(0, 1, 4'b0000, cs, "hold");
      check("hold.z0", 32'(lamp[4:0]), (i < HC) ? 32'b00100 : 32'd0);
    end

    // 3: retrigger on the timer==0 cycle, then a full fresh hold.
    step(0, 1, 4'b0001, cs, "relit");
    for (int i = 0; i < HC; i++) step(0, 1, 4'b0000, cs, "drain");
    step(0, 1, 4'b0001, cs, "retrig");
    check("retrig.act0", 32'(active[0]), 32'd1);
    for (int i = 0; i <= HC; i++) begin
      step(0, 1, 4'b0000, cs, "rehold");
      check("rehold.act0", 32'(active[0]), (i < HC) ? 32'd1 : 32'd0);
    end

    // 4: two zones in HOLD lose darkness; motion in daylight never lights.
    cs = sels(GREEN, 0, YELLOW, 0);
    step(0, 1, 4'b0101, cs, "two_on");
    step(0, 1, 4'b0000, cs, "two_hold");
    step(0, 0, 4'b0000, cs, "daylight");
    check("daylight.act", 32'(active), 32'd0);
    for (int i = 0; i < 3; i++) step(0, 0, 4'hf, cs, "day_motion");

    // 5: invalid colour keeps zone active with dark lamp; then WHITE.
    cs = sels(0, 5, 0, 0);
    step(0, 1, 4'b0010, cs, "invalid");
    check("invalid.act1", 32'(active[1]), 32'd1);
    check("invalid.lamp1", 32'(lamp[9:5]), 32'd0);
    cs = sels(0, WHITE, 0, 0);
    step(0, 1, 4'b0010, cs, "white");
    check("white.lamp1", 32'(lamp[9:5]), 32'b10000);

    // 6: reset zone3 mid-hold (timer 2), no residual hold after release.
    cs = sels(0, 0, 0, BLUE);
    step(0, 1, 4'b1000, cs, "z3_on");
    step(0, 1, 4'b0000, cs, "z3_t3");
    step(0, 1, 4'b0000, cs, "z3_t2");
    step(1, 1, 4'b0000, cs, "z3_rst");
    check("z3_rst.act3", 32'(active[3]), 32'd0);
    for (int i = 0; i < HC + 1; i++) step(0, 1, 4'b0000, cs, "z3_off");

    // Randomized traffic: sparse motion, mostly dark, occasional reset.
    for (int i = 0; i < 400; i++) begin
      for (int z = 0; z < NZ; z++) m[z] = ($urandom_range(0, 99) < 30);
      d  = ($urandom_range(0, 99) < 85);
      r  = ($urandom_range(0, 99) < 2);
      cs = NZ*SW'($urandom);
      step(r, d, m, cs, "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
